pc_sequencer: RTL and testbench



---
 rtl/kgp_pkg.sv | 12 +
 rtl/pc_ras_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared types and defaults for the KGPminiRISC fetch-stage blocks.
package kgp_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

  localparam int DEF_PC_W = 32;
  localparam int DEF_STEP = 4;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry. A pop on an empty stack is ignored. A push and a pop in the
// same cycle replace the top entry and leave the depth unchanged.
module pc_ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic          pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign top    = mem[ptr - PW'(1)];

  // Pointer/count bookkeeping and entry writes; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop_ok) begin
      mem[ptr - PW'(1)] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop_ok) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer with a RUN/HALT state machine, stall,
// aligned branch/jump redirect and a configurable step and reset vector.
// Optional feature macro: PC_RAS_EN adds a return-address stack
// (call_push / ret_pop). Without it those inputs are ignored.
module pc_sequencer
  import kgp_pkg::*;
#(
  parameter int              PC_W       = DEF_PC_W,
  parameter int              STEP       = DEF_STEP,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter int              ALIGN_BITS = 2,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_target,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_err
);

  localparam logic [PC_W-1:0] LOW_MASK = PC_W'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_t       state;
  logic [PC_W-1:0] pc_step;
  logic [PC_W-1:0] target_aligned;
  logic            target_misaligned;
  logic            ras_take;
  logic [PC_W-1:0] ras_top;

  assign pc_step           = pc + PC_W'(STEP);
  assign target_aligned    = redir_target & ~LOW_MASK;
  assign target_misaligned = |(redir_target & LOW_MASK);

`ifdef PC_RAS_EN
  logic ras_push;
  logic ras_pop;
  logic ras_empty;

  assign ras_push = call_push && (state == RUN) && !stall;
  assign ras_pop  = ret_pop && (state == RUN);
  assign ras_take = ras_pop && !ras_empty;

  pc_ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_step),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;

  assign unused_ras = ^{call_push, ret_pop, RAS_DEPTH[0]};
  assign ras_take   = 1'b0;
  assign ras_top    = '0;
`endif

  // RUN/HALT state machine and next-PC selection. A cycle with pc_valid low
  // in RUN (just out of reset or resume) fetches the held pc before stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_VEC;
      pc_valid     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redir_valid && target_misaligned;
      case (state)
        RUN: begin
          if (redir_valid)                          pc <= target_aligned;
          else if (ras_take)                        pc <= ras_top;
          else if (!(halt_req || stall || !pc_valid)) pc <= pc_step;
          if (halt_req) begin
            state    <= HALT;
            halted   <= 1'b1;
            pc_valid <= 1'b0;
          end else begin
            pc_valid <= 1'b1;
          end
        end
        HALT: begin
          if (redir_valid) pc <= target_aligned;
          if (resume && !halt_req) begin
            state    <= RUN;
            halted   <= 1'b0;
            pc_valid <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for sequencing, stall,
// redirect, halt and reset behaviour, and an 8-bit instance for wrap-around
// and a non-zero reset vector.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, redir_valid, halt_req, resume, call_push, ret_pop;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic        pc_valid, halted, misalign_err;

  logic        w_redir_valid;
  logic [7:0]  w_redir_target;
  logic [7:0]  w_pc;
  logic        w_pc_valid, w_halted, w_misalign_err;
  logic        w_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .call_push    (call_push),
    .ret_pop      (ret_pop),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  pc_sequencer #(
    .PC_W      (8),
    .STEP      (4),
    .RESET_VEC (8'hF0)
  ) dut_w8 (
    .clk          (clk),
    .rst          (rst),
    .stall        (w_zero),
    .redir_valid  (w_redir_valid),
    .redir_target (w_redir_target),
    .halt_req     (w_zero),
    .resume       (w_zero),
    .call_push    (w_zero),
    .ret_pop      (w_zero),
    .pc           (w_pc),
    .pc_valid     (w_pc_valid),
    .halted       (w_halted),
    .misalign_err (w_misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic e_halted, input logic e_mis);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
    check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, e_mis});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
    halt_req = 1'b0; resume = 1'b0; call_push = 1'b0; ret_pop = 1'b0;
    w_redir_valid = 1'b0; w_redir_target = '0; w_zero = 1'b0;

    // Reset for two cycles
    step(); step();
    check_main("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.w8_pc", {24'd0, w_pc}, 32'h0000_00F0);
    check("reset.w8_valid", {31'd0, w_pc_valid}, 32'd0);

    // Release: first fetch at the reset vector, then sequential steps
    rst = 1'b0;
    step(); check_main("seq0", 32'h0, 1'b1, 1'b0, 1'b0);
    check("seq0.w8_pc", {24'd0, w_pc}, 32'h0000_00F0);
    step(); check("seq1", pc, 32'h4);
    step(); check("seq2", pc, 32'h8);
    step(); check("seq3", pc, 32'hC);
    step(); check("seq4", pc, 32'h10);

    // Stall holds pc; redirect overrides stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", pc, 32'h10);
    end
    redir_valid = 1'b1; redir_target = 32'h100;
    step(); check_main("redir_over_stall", 32'h100, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; redir_valid = 1'b0;

    // Misaligned redirect: low bits cleared, one-cycle error pulse
    redir_valid = 1'b1; redir_target = 32'h203;
    step(); check_main("misalign", 32'h200, 1'b1, 1'b0, 1'b1);
    redir_valid = 1'b0;
    step(); check_main("misalign_end", 32'h204, 1'b1, 1'b0, 1'b0);

    // Halt, redirect while halted, resume
    redir_valid = 1'b1; redir_target = 32'h40;
    step(); check("to_0x40", pc, 32'h40);
    redir_valid = 1'b0; halt_req = 1'b1;
    step(); check_main("halt", 32'h40, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0;
    step(); check_main("halt_hold", 32'h40, 1'b0, 1'b1, 1'b0);
    redir_valid = 1'b1; redir_target = 32'h80;
    step(); check_main("halt_redir", 32'h80, 1'b0, 1'b1, 1'b0);
    redir_valid = 1'b0; resume = 1'b1;
    step(); check_main("resume", 32'h80, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    step(); check_main("resume_step", 32'h84, 1'b1, 1'b0, 1'b0);

    // halt_req beats resume, in both states
    halt_req = 1'b1; resume = 1'b1;
    step(); check_main("both_run", 32'h84, 1'b0, 1'b1, 1'b0);
    step(); check_main("both_halt", 32'h84, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0;
    step(); check_main("resume2", 32'h84, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    step(); check("resume2_step", pc, 32'h88);

    // Reset asserted in the middle of a stall
    stall = 1'b1;
    step(); check("pre_rst_stall", pc, 32'h88);
    rst = 1'b1;
    step(); check_main("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step(); check_main("mid_rst_rel", 32'h0, 1'b1, 1'b0, 1'b0);

    // Pop with an empty (or absent) stack falls through to pc+STEP
    ret_pop = 1'b1;
    step(); check_main("pop_empty", 32'h4, 1'b1, 1'b0, 1'b0);
    ret_pop = 1'b0;

`ifdef PC_RAS_EN
    // Five pushes into a 4-deep stack, then five pops
    redir_valid = 1'b1; redir_target = 32'h10;
    step(); check("ras_start", pc, 32'h10);
    call_push = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      redir_target = 32'(k * 16);
      step(); check("ras_push", pc, 32'(k * 16));
    end
    redir_valid = 1'b0;
    step(); check("ras_push_last", pc, 32'h54);
    call_push = 1'b0; ret_pop = 1'b1;
    step(); check("ras_pop1", pc, 32'h54);
    step(); check("ras_pop2", pc, 32'h44);
    step(); check("ras_pop3", pc, 32'h34);
    step(); check("ras_pop4", pc, 32'h24);
    step(); check_main("ras_pop_empty", 32'h28, 1'b1, 1'b0, 1'b0);
    ret_pop = 1'b0;
`else
    // Without the stack, call/return requests are ignored
    call_push = 1'b1; ret_pop = 1'b1;
    step(); check("ras_ignored", pc, 32'h8);
    call_push = 1'b0; ret_pop = 1'b0;
    step(); check("ras_ignored2", pc, 32'hC);
`endif

    // 8-bit instance: step past 0xFC wraps to 0x00 without error
    w_redir_valid = 1'b1; w_redir_target = 8'hFC;
    step(); check("w8_fc", {24'd0, w_pc}, 32'h0000_00FC);
    w_redir_valid = 1'b0;
    step(); check("w8_wrap", {24'd0, w_pc}, 32'h0);
    check("w8_wrap_err", {31'd0, w_misalign_err}, 32'd0);
    check("w8_halted", {31'd0, w_halted}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
